// File: rtl/m31_mds_pkg.sv
// Shared types and constants for the M31 Monolith MDS matrix-vector sequencer.
// Contents: field modulus, default circulant first row, FSM state enum, word type.
package m31_mds_pkg;

  typedef logic [30:0] m31_word_t;

  localparam m31_word_t M31_P = 31'h7FFF_FFFF;

  localparam m31_word_t MDS_ROW0_DEFAULT [0:15] = '{
    31'd61402, 31'd17845, 31'd26798, 31'd59689,
    31'd12021, 31'd40901, 31'd41351, 31'd27521,
    31'd56951, 31'd12034, 31'd53865, 31'd43244,
    31'd7454,  31'd33823, 31'd28750, 31'd1108
  };

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } seq_state_e;

endpackage

// File: rtl/vector_dot_product.sv
// Combinational dot product of two word vectors reduced mod 2^W-1.
// Ports: vec1_i, vec2_i (VECTOR_SIZE words each) -> result_o (canonical word).
module vector_dot_product #(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16
) (
  input  logic [WORD_WIDTH-1:0] vec1_i [VECTOR_SIZE],
  input  logic [WORD_WIDTH-1:0] vec2_i [VECTOR_SIZE],
  output logic [WORD_WIDTH-1:0] result_o
);

  localparam int unsigned L   = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int unsigned SW  = 2 * WORD_WIDTH + L;
  localparam int unsigned AW  = WORD_WIDTH + L + 1;
  localparam int unsigned W1  = WORD_WIDTH + 1;
  localparam logic [W1-1:0] P_EXT = {1'b0, {WORD_WIDTH{1'b1}}};

  logic [SW-1:0] sum;
  logic [AW-1:0] fold_a;
  logic [W1-1:0] fold_b;
  logic [W1-1:0] fold_c;

  always_comb begin
    sum = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      sum = sum + SW'(vec1_i[i]) * SW'(vec2_i[i]);
    end
  end

  // 2^W == 1 mod p, so high bits fold onto the low word.
  assign fold_a = AW'(sum[WORD_WIDTH-1:0]) + AW'(sum[SW-1:WORD_WIDTH]);
  assign fold_b = W1'(fold_a[WORD_WIDTH-1:0]) + W1'(fold_a[AW-1:WORD_WIDTH]);
  assign fold_c = W1'(fold_b[WORD_WIDTH-1:0]) + W1'(fold_b[WORD_WIDTH]);

  assign result_o = (fold_c >= P_EXT) ? WORD_WIDTH'(fold_c - P_EXT)
                                      : fold_c[WORD_WIDTH-1:0];

endmodule

// File: rtl/mds_matvec_sequencer.sv
// Word-serial 16x16 circulant MDS matrix-vector product over M31, one row per cycle.
// Ports: in_valid/in_ready/in_state in, out_valid/out_ready/out_state out, busy.
module mds_matvec_sequencer
  import m31_mds_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16,
  parameter logic [WORD_WIDTH-1:0] MDS_ROW0 [VECTOR_SIZE] = MDS_ROW0_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_state [VECTOR_SIZE],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_state [VECTOR_SIZE],
  output logic                  busy
);

  localparam int unsigned CW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(VECTOR_SIZE - 1);
  localparam logic [WORD_WIDTH-1:0] P_W = WORD_WIDTH'(M31_P);

  if ((VECTOR_SIZE < 2) || ((VECTOR_SIZE & (VECTOR_SIZE - 1)) != 0)) begin : g_size_chk
    $error("VECTOR_SIZE must be a power of two");
  end

  seq_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [WORD_WIDTH-1:0] buf_q   [VECTOR_SIZE];
  logic [WORD_WIDTH-1:0] out_q   [VECTOR_SIZE];
  logic [WORD_WIDTH-1:0] row_vec [VECTOR_SIZE];
  logic [WORD_WIDTH-1:0] dot;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;

  // Row r of the circulant: element c = ROW0[(c - r) mod N], wrap via CW bits.
  for (genvar c = 0; c < VECTOR_SIZE; c++) begin : g_rot
    localparam logic [CW-1:0] CI = CW'(c);
    logic [CW-1:0] idx;
    assign idx        = CI - cnt_q;
    assign row_vec[c] = MDS_ROW0[idx];
  end

  vector_dot_product #(
    .WORD_WIDTH (WORD_WIDTH),
    .VECTOR_SIZE(VECTOR_SIZE)
  ) u_dot (
    .vec1_i  (buf_q),
    .vec2_i  (row_vec),
    .result_o(dot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '{default: '0};
      out_q       <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Non-canonical p is the same field element as 0.
            for (int i = 0; i < VECTOR_SIZE; i++) begin
              buf_q[i] <= (in_state[i] == P_W) ? '0 : in_state[i];
            end
            cnt_q      <= '0;
            state_q    <= COMPUTE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        COMPUTE: begin
          out_q[cnt_q] <= dot;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          // A simultaneous in_valid is not taken here; IDLE takes it next edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = out_q;

endmodule
